prefix_adder_pipe: RTL and testbench
====================================

Name: prefix_adder_pipe

Overview:
- Parametrised, pipelined parallel-prefix (Kogge-Stone) adder/subtractor. Successor to the fixed 8-bit combinational prefix adder.
- Generalised in width, with add/sub mode, carry-out, signed overflow and a valid/ready stream handshake.
- Registered after every prefix level for high clock rate. Used as the shared arithmetic unit in datapath pipelines.

Parameters:
- WIDTH, 16, operand/sum width in bits; legal 2..64.
- LEVELS, $clog2(WIDTH), number of prefix levels. Derived localparam, not overridable.
- LAT, LEVELS+2, pipeline latency in cycles. Derived localparam.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  adder can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB. For sub: 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert on rst=1, sync release): all stage valid bits=0, out_valid=0, sum=0, cout=0, ovf=0. Data registers may also clear; clearing all is required for deterministic X-free sim.
- Stage 0 (input register):
  - b' = sub ? ~b : b; c0 = sub ? 1 : cin.
  - g_i = a_i & b'_i; p_i = a_i ^ b'_i.
  - Register g, p, c0, and a[MSB]/b'[MSB] for ovf.
- Stages 1..LEVELS (prefix levels): level k combines bit i with bit i-2^(k-1) when i >= 2^(k-1): G = Gh | (Ph & Gl), P = Ph & Pl. Other bits pass through. Each level is registered.
- c0 folds in as a generate entering below bit 0, so bit i carry = G[i-1:0] | (P[i-1:0] & c0).
- Final stage:
  - sum_i = p_i ^ carry_i.
  - cout = carry_WIDTH.
  - ovf = carry_WIDTH ^ carry_(WIDTH-1).
  - Registered outputs.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+LAT, when there are no stalls.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - Global-stall pipeline: in_ready = ~out_valid | out_ready. When in_ready=0, every stage holds.
  - in_ready is combinational from out_ready; no other combinational in->out path.
  - While out_valid=1 & out_ready=0, sum/cout/ovf are held stable.
  - Bubbles (stage valid=0) propagate and are never emitted.
- Throughput: 1 beat/cycle while out_ready=1.
- Simultaneous accept and emit in the same cycle is legal and must lose no beat.
- Mid-operation reset drops all in-flight beats; first out_valid comes no earlier than LAT cycles after the first post-reset accept.
- Width wrap: sum is modulo 2^WIDTH; the carry is only visible on cout.

Optional Feature:
- Macro: PREFIX_ADDER_SAT_EN.
- Defined: adds input port sat (1 bit), pipelined alongside the data. When sat=1 and ovf=1, sum clamps to the signed extreme: 0111..1 if the true result is positive (operand sign bits, after b inversion, both 0), else 1000..0. cout and ovf still report the raw values.
- Undefined: no sat port; sum always wraps.

Test Plan (WIDTH=16, LAT=6):
- After reset, a=0x1234, b=0x0FED, cin=1, sub=0, out_ready=1 -> out_valid exactly 6 cycles later; sum=0x2222, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0. Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Back-to-back stream of 20 random beats, out_ready held low for cycles 8-11 -> in_ready low during the stall, outputs held stable, all 20 results in order and correct vs. reference model, no duplicates.
- Assert rst for 1 cycle with 4 beats in flight -> out_valid=0 next cycle, none of the 4 beats ever emitted. New beat accepted after reset emerges 6 cycles later.
- With PREFIX_ADDER_SAT_EN defined: sat=1, a=0x7FFF, b=0x0001 -> sum=0x7FFF, ovf=1. Then sat=1, sub=1, a=0x8000, b=0x0001 -> sum=0x8000, ovf=1.

Source files
------------

// File: rtl/prefix_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : prefix_adder_pipe
// Description : Pipelined Kogge-Stone adder/subtractor with valid/ready
//               stream handshake, carry-out and signed overflow. There is one
//               input register, one register per prefix level, and one output
//               register, which gives a latency of LEVELS+2 cycles.
//               Optional macro PREFIX_ADDER_SAT_EN adds a 'sat' input. When
//               'sat' is set, a result that overflows is clamped to the signed
//               extreme.
// Revision    : 1.0 - initial parametrised pipelined release
// ============================================================================
module prefix_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef PREFIX_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LAT    = LEVELS + 2;

  // Stage valid bits. Bit 0 is the input register, bits 1..LEVELS are the
  // prefix levels, and bit LAT-1 is the output register.
  logic [LAT-1:0]               vld_q;

  // Group generate/propagate terms. Index k holds the value after level k.
  logic [LEVELS:0][WIDTH-1:0]   g_q, p_q;
  logic [LEVELS:0][WIDTH-1:0]   g_d, p_d;

  // The raw bit propagate (needed for the sum) and the carry-in travel
  // alongside the prefix terms.
  logic [LEVELS:0][WIDTH-1:0]   pz_q;
  logic [LEVELS:0]              c0_q;

  logic [WIDTH-1:0]             b_inv;
  logic                         c0_d;
  logic                         adv;

  logic [WIDTH:0]               carry;
  logic [WIDTH-1:0]             sum_d;
  logic                         cout_d, ovf_d;
  logic [WIDTH-1:0]             sum_q;
  logic                         cout_q, ovf_q;

`ifdef PREFIX_ADDER_SAT_EN
  logic [LEVELS:0]              sat_q, an_q, bn_q;
`endif

  // The pipeline uses a global stall: every stage moves together, or every
  // stage holds.
  assign adv       = ~vld_q[LAT-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[LAT-1];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Operand conditioning. Subtraction is A + ~B + 1, so cin is ignored when sub=1.
  always_comb begin
    b_inv  = sub ? ~b : b;
    c0_d   = sub | cin;
    g_d[0] = a & b_inv;
    p_d[0] = a ^ b_inv;
  end

  // Kogge-Stone levels. At level k, bit i merges with bit i-2^(k-1).
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_cmb
        assign g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-D]);
        assign p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-D];
      end else begin : g_pass
        assign g_d[k][i] = g_q[k-1][i];
        assign p_d[k][i] = p_q[k-1][i];
      end
    end
  end

  // Input register and prefix-level registers. All of them advance together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      g_q   <= '0;
      p_q   <= '0;
      pz_q  <= '0;
      c0_q  <= '0;
`ifdef PREFIX_ADDER_SAT_EN
      sat_q <= '0;
      an_q  <= '0;
      bn_q  <= '0;
`endif
    end else if (adv) begin
      vld_q <= {vld_q[LAT-2:0], in_valid};
      g_q   <= g_d;
      p_q   <= p_d;
      pz_q  <= {pz_q[LEVELS-1:0], p_d[0]};
      c0_q  <= {c0_q[LEVELS-1:0], c0_d};
`ifdef PREFIX_ADDER_SAT_EN
      sat_q <= {sat_q[LEVELS-1:0], sat};
      an_q  <= {an_q[LEVELS-1:0], a[WIDTH-1]};
      bn_q  <= {bn_q[LEVELS-1:0], b_inv[WIDTH-1]};
`endif
    end
  end

  // Final stage. The carry-in acts as a generate just below bit 0, so
  // carry[i+1] = G[i:0] | (P[i:0] & c0).
  always_comb begin
    carry[0] = c0_q[LEVELS];
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = g_q[LEVELS][i] | (p_q[LEVELS][i] & c0_q[LEVELS]);
    end
    sum_d  = pz_q[LEVELS] ^ carry[WIDTH-1:0];
    cout_d = carry[WIDTH];
    ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
`ifdef PREFIX_ADDER_SAT_EN
    // When the result overflows, both operand signs are equal and give the true sign.
    if (sat_q[LEVELS] && ovf_d) begin
      sum_d = (~an_q[LEVELS] & ~bn_q[LEVELS]) ? {1'b0, {(WIDTH-1){1'b1}}}
                                              : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  // Output register. It holds its value while the downstream stage stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prefix_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefix_adder_pipe
// Description : Self-checking bench for prefix_adder_pipe (WIDTH=16, LAT=6).
//               Directed cases plus a random stream against an arithmetic
//               reference model. Honours PREFIX_ADDER_SAT_EN.
// Revision    : 1.0
// ============================================================================
module tb_prefix_adder_pipe;

  localparam int W   = 16;
  localparam int LAT = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub, sat;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf;

  int           n_chk = 0;
  int           n_err = 0;
  int           rcv   = 0;
  bit           mon_en = 1'b0;
  bit           hold_prev = 1'b0;
  logic [17:0]  prev_res;
  logic [17:0]  exp_q[$];

  prefix_adder_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
`ifdef PREFIX_ADDER_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain (W+1)-bit arithmetic. Returns {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb, input logic st);
    logic [15:0] yy;
    logic [16:0] full;
    logic [15:0] s;
    logic        o;
    yy   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + (sb ? 17'd1 : {16'd0, ci});
    s    = full[15:0];
    o    = (x[15] == yy[15]) && (s[15] != x[15]);
`ifdef PREFIX_ADDER_SAT_EN
    if (st && o) s = x[15] ? 16'h8000 : 16'h7FFF;
`else
    if (st) s = full[15:0];
`endif
    return {o, full[16], s};
  endfunction

  // Send one isolated beat, then check its latency, its value, and that it is emitted only once.
  task automatic run_single(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                            input logic tc, input logic ts, input logic tsat,
                            input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb; cin = tc; sub = ts; sat = tsat; in_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    @(negedge clk);
    chk({tag, "_no_dup"}, 64'(out_valid), 64'd0);
  endtask

  // Stream monitor: checks results in order and checks that outputs stay stable during a stall.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && out_valid) begin
        if (hold_prev) chk("stall_hold", 64'({ovf, cout, sum}), 64'(prev_res));
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            chk("stream_res", 64'({ovf, cout, sum}), 64'(e));
            rcv++;
          end
        end
        hold_prev = !out_ready;
        prev_res  = {ovf, cout, sum};
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int idx;
    int vcnt;
    logic [15:0] ra, rb;
    logic        rc, rs, rt;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed arithmetic cases
    run_single("add_basic", 16'h1234, 16'h0FED, 1'b1, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0);
    run_single("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_single("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_single("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_single("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`ifdef PREFIX_ADDER_SAT_EN
    run_single("sat_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    run_single("sat_neg",   16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
`endif

    // Random back-to-back stream with a downstream stall in cycles 8..11
    mon_en = 1'b1; rcv = 0; idx = 0; acc = 1'b0;
    for (int cyc = 0; cyc < 100 && rcv < 20; cyc++) begin
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      out_ready = !(cyc >= 8 && cyc <= 11);
      if (!in_valid && idx < 20) begin
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom); rs = 1'($urandom);
`ifdef PREFIX_ADDER_SAT_EN
        rt = 1'($urandom);
`else
        rt = 1'b0;
`endif
        a = ra; b = rb; cin = rc; sub = rs; sat = rt; in_valid = 1'b1;
      end
      @(negedge clk);
      if (!out_ready && out_valid) chk("stall_in_ready", 64'(in_ready), 64'd0);
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(model(a, b, cin, sub, sat));
        idx++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", 64'(rcv), 64'd20);
    chk("stream_leftover", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    mon_en = 1'b0;

    // Reset while four beats are in flight
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'b0; sub = 1'b0; sat = 1'b0;
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("midrst_no_emit", 64'(vcnt), 64'd0);
    run_single("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
